// File: rtl/traffic_light_sequencer.sv
// traffic_light_sequencer: tick-timed Moore sequencer for a two-way intersection (green/yellow/all-red, walk, flash, emergency).
// Latency: outputs decode the state register; a tick or mode change shows on the outputs one clk later.
// Backpressure: none; tick and currentMode are sampled every clk. Optional night flash built with `define TL_NIGHT_FLASH_EN.
module traffic_light_sequencer #(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 5,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] currentMode,
    output logic [2:0] nsLights,
    output logic [2:0] ewLights,
    output logic       walk,
    output logic [3:0] phase
);

    // Mode codes after priority resolution
    localparam logic [1:0] M_DAY   = 2'b00;
    localparam logic [1:0] M_NIGHT = 2'b01;
    localparam logic [1:0] M_PED   = 2'b10;
    localparam logic [1:0] M_EMG   = 2'b11;

    // Lamp patterns {red, yellow, green}
    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    // Counter reload values (duration - 1)
    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(WALK_TICKS - 1);

    // Which green follows the next all-red / walk phase
    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    typedef enum logic [3:0] {
        S_NSG   = 4'd0,
        S_NSY   = 4'd1,
        S_ARN   = 4'd2,
        S_EWG   = 4'd3,
        S_EWY   = 4'd4,
        S_ARE   = 4'd5,
        S_WALK  = 4'd6,
`ifdef TL_NIGHT_FLASH_EN
        S_FLASH = 4'd7,
`endif
        S_EMG   = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ld_val;
    logic             nextdir_q, nextdir_d;
    logic             expire;
    logic [1:0]       mode_eff;

`ifdef TL_NIGHT_FLASH_EN
    logic             flash_on_q, flash_on_d;
    assign mode_eff = currentMode;
`else
    // Without the flash feature night mode behaves exactly like day mode
    assign mode_eff = (currentMode == M_NIGHT) ? M_DAY : currentMode;
`endif

    // The current phase has run its full length when a tick lands on cnt==0
    assign expire = tick && (cnt_q == '0);

    // State, counter and side registers; reset lands in all-red with NS next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_ARE;
            cnt_q      <= LD_ALLRED;
            nextdir_q  <= DIR_NS;
`ifdef TL_NIGHT_FLASH_EN
            flash_on_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nextdir_q  <= nextdir_d;
`ifdef TL_NIGHT_FLASH_EN
            flash_on_q <= flash_on_d;
`endif
        end
    end

    // Next-state: expiry-driven sequencing plus clk-level preemption
    always_comb begin
        state_d   = state_q;
        nextdir_d = nextdir_q;
        case (state_q)
            S_NSG: begin
                // Pedestrian or emergency cuts green short; night never does
                if (mode_eff[1] || expire) state_d = S_NSY;
            end
            S_NSY: begin
                // Yellow always runs to completion
                if (expire) state_d = (mode_eff == M_EMG) ? S_EMG : S_ARN;
            end
            S_ARN: begin
                if (mode_eff == M_EMG) begin
                    state_d   = S_EMG;
                    nextdir_d = DIR_EW;
                end else if (expire) begin
                    nextdir_d = DIR_EW;
                    case (mode_eff)
                        M_PED:   state_d = S_WALK;
`ifdef TL_NIGHT_FLASH_EN
                        M_NIGHT: state_d = S_FLASH;
`endif
                        default: state_d = S_EWG;
                    endcase
                end
            end
            S_EWG: begin
                if (mode_eff[1] || expire) state_d = S_EWY;
            end
            S_EWY: begin
                if (expire) state_d = (mode_eff == M_EMG) ? S_EMG : S_ARE;
            end
            S_ARE: begin
                if (mode_eff == M_EMG) begin
                    state_d   = S_EMG;
                    nextdir_d = DIR_NS;
                end else if (expire) begin
                    nextdir_d = DIR_NS;
                    case (mode_eff)
                        M_PED:   state_d = S_WALK;
`ifdef TL_NIGHT_FLASH_EN
                        M_NIGHT: state_d = S_FLASH;
`endif
                        default: state_d = S_NSG;
                    endcase
                end
            end
            S_WALK: begin
                if (mode_eff == M_EMG) begin
                    state_d = S_EMG;
                end else if (expire) begin
                    state_d = (nextdir_q == DIR_EW) ? S_EWG : S_NSG;
                end
            end
`ifdef TL_NIGHT_FLASH_EN
            S_FLASH: begin
                if (mode_eff == M_EMG) begin
                    state_d = S_EMG;
                end else if (mode_eff != M_NIGHT) begin
                    state_d = S_ARE;
                end
            end
`endif
            S_EMG: begin
                // Leaving emergency always clears through all-red toward NS
                if (mode_eff != M_EMG) state_d = S_ARE;
            end
            default: begin
                state_d = S_ARE;
            end
        endcase
    end

    // Reload value for whichever state is being entered
    always_comb begin
        ld_val = '0;
        case (state_d)
            S_NSG, S_EWG: ld_val = LD_GREEN;
            S_NSY, S_EWY: ld_val = LD_YELLOW;
            S_ARN, S_ARE: ld_val = LD_ALLRED;
            S_WALK:       ld_val = LD_WALK;
            default:      ld_val = '0;
        endcase
    end

    // Counter: reload on entry (a coincident tick is dropped), else count ticks down
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = ld_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

`ifdef TL_NIGHT_FLASH_EN
    // Flash blinker: starts lit on FLASH entry, toggles each tick while flashing
    always_comb begin
        flash_on_d = flash_on_q;
        if ((state_d == S_FLASH) && (state_q != S_FLASH)) begin
            flash_on_d = 1'b1;
        end else if ((state_q == S_FLASH) && tick) begin
            flash_on_d = ~flash_on_q;
        end
    end
`endif

    // Lamp decode from registered state only, so outputs never glitch on inputs
    always_comb begin
        nsLights = L_RED;
        ewLights = L_RED;
        walk     = 1'b0;
        phase    = state_q;
        case (state_q)
            S_NSG: begin
                nsLights = L_GRN;
                ewLights = L_RED;
            end
            S_NSY: begin
                nsLights = L_YEL;
                ewLights = L_RED;
            end
            S_EWG: begin
                nsLights = L_RED;
                ewLights = L_GRN;
            end
            S_EWY: begin
                nsLights = L_RED;
                ewLights = L_YEL;
            end
            S_WALK: begin
                walk = 1'b1;
            end
`ifdef TL_NIGHT_FLASH_EN
            S_FLASH: begin
                nsLights = flash_on_q ? L_YEL : L_OFF;
                ewLights = flash_on_q ? L_RED : L_OFF;
            end
`endif
            default: begin
                nsLights = L_RED;
                ewLights = L_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// tb_traffic_light_sequencer: directed self-checking bench for traffic_light_sequencer.
// Ticks every 4 clks; inputs driven and outputs sampled on the falling clk edge.
// Checks reset, day cycle, pedestrian/emergency preemption, night mode and async reset.
module tb_traffic_light_sequencer;

    localparam logic [3:0] P_NSG   = 4'd0;
    localparam logic [3:0] P_NSY   = 4'd1;
    localparam logic [3:0] P_ARN   = 4'd2;
    localparam logic [3:0] P_EWG   = 4'd3;
    localparam logic [3:0] P_EWY   = 4'd4;
    localparam logic [3:0] P_ARE   = 4'd5;
    localparam logic [3:0] P_WALK  = 4'd6;
    localparam logic [3:0] P_FLASH = 4'd7;
    localparam logic [3:0] P_EMG   = 4'd8;

    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [1:0] currentMode;
    logic [2:0] nsLights;
    logic [2:0] ewLights;
    logic       walk;
    logic [3:0] phase;

    int n_tests = 0;
    int n_fail  = 0;

    traffic_light_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .currentMode (currentMode),
        .nsLights    (nsLights),
        .ewLights    (ewLights),
        .walk        (walk),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    // Compare {phase, ns, ew, walk} against the expected vector
    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got phase=%0d ns=%b ew=%b walk=%b, expected phase=%0d ns=%b ew=%b walk=%b",
                     tag, got[10:7], got[6:4], got[3:1], got[0], exp[10:7], exp[6:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic look(input string tag, input logic [3:0] ph, input logic [2:0] ns,
                        input logic [2:0] ew, input logic wk);
        check(tag, {phase, nsLights, ewLights, walk}, {ph, ns, ew, wk});
    endtask

    // One tick strobe followed by three idle clks; starts and ends on a falling edge
    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Expect the given outputs before each of n ticks
    task automatic hold(input string tag, input logic [3:0] ph, input logic [2:0] ns,
                        input logic [2:0] ew, input logic wk, input int n);
        for (int i = 0; i < n; i++) begin
            look($sformatf("%s[%0d]", tag, i), ph, ns, ew, wk);
            pulse_tick();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        look("reset_assert", P_ARE, R, R, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic day_trace(input string pfx);
        hold({pfx, "_are0"}, P_ARE, R, R, 1'b0, 1);
        hold({pfx, "_nsg"},  P_NSG, G, R, 1'b0, 8);
        hold({pfx, "_nsy"},  P_NSY, Y, R, 1'b0, 3);
        hold({pfx, "_arn"},  P_ARN, R, R, 1'b0, 1);
        hold({pfx, "_ewg"},  P_EWG, R, G, 1'b0, 8);
        hold({pfx, "_ewy"},  P_EWY, R, Y, 1'b0, 3);
        hold({pfx, "_are"},  P_ARE, R, R, 1'b0, 1);
        look({pfx, "_nsg_again"}, P_NSG, G, R, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        tick        = 1'b0;
        currentMode = 2'b00;
        #1;
        look("por", P_ARE, R, R, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Day cycle
        day_trace("day");

        // Pedestrian preempts green at cnt=5, with a coincident tick that must be dropped
        do_reset();
        hold("ped_are0", P_ARE, R, R, 1'b0, 1);
        hold("ped_nsg",  P_NSG, G, R, 1'b0, 2);
        currentMode = 2'b10;
        tick        = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        hold("ped_nsy",  P_NSY, Y, R, 1'b0, 3);
        hold("ped_arn",  P_ARN, R, R, 1'b0, 1);
        currentMode = 2'b00;
        hold("ped_walk", P_WALK, R, R, 1'b1, 5);
        hold("ped_ewg",  P_EWG, R, G, 1'b0, 8);

        // Emergency during yellow at cnt=1: yellow finishes, then EMG holds
        hold("emg_ewy0", P_EWY, R, Y, 1'b0, 1);
        currentMode = 2'b11;
        @(negedge clk);
        hold("emg_ewy",  P_EWY, R, Y, 1'b0, 2);
        hold("emg_hold", P_EMG, R, R, 1'b0, 20);
        currentMode = 2'b00;
        @(negedge clk);
        hold("emg_are",  P_ARE, R, R, 1'b0, 1);
        look("emg_nsg",  P_NSG, G, R, 1'b0);

        // Night mode from reset
        currentMode = 2'b01;
        do_reset();
`ifdef TL_NIGHT_FLASH_EN
        hold("fl_are", P_ARE, R, R, 1'b0, 1);
        look("fl_on0", P_FLASH, Y, R, 1'b0);
        pulse_tick();
        look("fl_off0", P_FLASH, OFF, OFF, 1'b0);
        pulse_tick();
        look("fl_on1", P_FLASH, Y, R, 1'b0);
        pulse_tick();
        look("fl_off1", P_FLASH, OFF, OFF, 1'b0);
        currentMode = 2'b11;
        @(negedge clk);
        look("fl_emg", P_EMG, R, R, 1'b0);
        currentMode = 2'b00;
        @(negedge clk);
        look("fl_exit_are", P_ARE, R, R, 1'b0);
`else
        day_trace("night");
        currentMode = 2'b00;
`endif

        // Async reset in the middle of EWG
        do_reset();
        hold("rst_are0", P_ARE, R, R, 1'b0, 1);
        hold("rst_nsg",  P_NSG, G, R, 1'b0, 8);
        hold("rst_nsy",  P_NSY, Y, R, 1'b0, 3);
        hold("rst_arn",  P_ARN, R, R, 1'b0, 1);
        hold("rst_ewg",  P_EWG, R, G, 1'b0, 3);
        rst = 1'b1;
        #1;
        look("rst_async", P_ARE, R, R, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        hold("rst_are1", P_ARE, R, R, 1'b0, 1);
        look("rst_nsg1", P_NSG, G, R, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
